// File: rtl/cory_arb_pkg.sv
// Shared types and helpers for the cory round-robin arbiter.
package cory_arb_pkg;

  localparam int unsigned RR_M_MAX = 16;
  localparam int unsigned RR_M_DEF = 4;
  localparam int unsigned RR_B_DEF = 2;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // Priority pointer rests on the last requester, so requester 0 wins first.
  function automatic int unsigned rr_ptr_rst(input int unsigned m);
    return m - 1;
  endfunction

  // First set bit of req searching ptr+1, ptr+2, ... modulo m.
  function automatic rr_pick_t rr_pick(input logic [RR_M_MAX-1:0] req,
                                       input int unsigned         ptr,
                                       input int unsigned         m);
    rr_pick_t   res;
    logic [3:0] k;
    res = '0;
    for (int unsigned i = 1; i <= RR_M_MAX; i++) begin
      k = 4'((ptr + i) % m);
      if (i <= m && !res.found && req[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cory_rr_pick.sv
// Combinational round-robin selector: next requester after ptr with valid set.
module cory_rr_pick
  import cory_arb_pkg::*;
#(
  parameter int unsigned M = RR_M_DEF,
  parameter int unsigned B = RR_B_DEF
) (
  input  logic [M-1:0] req_i,
  input  logic [B-1:0] ptr_i,
  output logic         found_o,
  output logic [B-1:0] idx_o
);

  logic [RR_M_MAX-1:0] req_ext;
  rr_pick_t            pick;

  always_comb begin
    req_ext = RR_M_MAX'(req_i);
    pick    = rr_pick(req_ext, 32'(ptr_i), M);
    found_o = pick.found;
    idx_o   = '0;
    for (int unsigned k = 0; k < M; k++) begin
      if (pick.idx == 4'(k)) idx_o = B'(k);
    end
  end

endmodule

// File: rtl/cory_rr_arb.sv
// Round-robin arbiter of M valid/ready requesters onto one sink, packet-locked.
module cory_rr_arb
  import cory_arb_pkg::*;
#(
  parameter int unsigned N = 64,
  parameter int unsigned M = RR_M_DEF,
  parameter int unsigned B = RR_B_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [M-1:0]   i_v,
  input  logic [M*N-1:0] i_d,
  input  logic [M-1:0]   i_l,
  output logic [M-1:0]   o_r,
  output logic           o_v,
  output logic [N-1:0]   o_d,
  output logic           o_l,
  input  logic           i_r,
  output logic [M-1:0]   o_g,
  output logic [B-1:0]   o_idx
);

  localparam logic [B-1:0] PTR_RST = B'(rr_ptr_rst(M));

  logic [B-1:0] ptr_q, ptr_d;
  logic [B-1:0] own_q, own_d;
  logic         own_v_q, own_v_d;

  logic         pick_found;
  logic [B-1:0] pick_idx;
  logic [B-1:0] sel;
  logic [M-1:0] sel_oh;
  logic         v_int, l_int, hs;
  logic [N-1:0] d_int;

  cory_rr_pick #(.M(M), .B(B)) u_pick (
    .req_i   (i_v),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Outputs are gated by reset_n so nothing is presented while in reset.
  always_comb begin
    sel    = own_v_q ? own_q : pick_idx;
    sel_oh = '0;
    v_int  = 1'b0;
    l_int  = 1'b0;
    d_int  = '0;
    o_r    = '0;
    for (int unsigned k = 0; k < M; k++) begin
      if (sel == B'(k)) begin
        sel_oh[k] = 1'b1;
        v_int     = own_v_q ? i_v[k] : pick_found;
        d_int     = i_d[k*N +: N];
        l_int     = i_l[k];
        o_r[k]    = i_r & reset_n;
      end
    end
    o_v   = v_int & reset_n;
    o_d   = reset_n ? d_int : '0;
    o_l   = l_int & reset_n;
    o_g   = o_v ? sel_oh : '0;
    o_idx = o_v ? sel : '0;
    hs    = o_v & i_r;
  end

  // A presented beat locks the owner whether or not it was accepted,
  // unless it is an accepted last beat.
  always_comb begin
    ptr_d   = ptr_q;
    own_d   = own_q;
    own_v_d = own_v_q;
    if (hs && o_l) begin
      own_v_d = 1'b0;
      ptr_d   = sel;
    end else if (o_v) begin
      own_v_d = 1'b1;
      own_d   = sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= PTR_RST;
      own_q   <= '0;
      own_v_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      own_v_q <= own_v_d;
    end
  end

endmodule
